clk_gen_ctrl: RTL

Synthesizable programmable clock-generator controller. It derives a divided clock `clk_out` from the reference clock `clk`. Period, high time and start phase are programmed in reference-clock cycles through a valid/ready config port. A phase/high/low FSM sequences the output. New configurations are applied glitch-free at period boundaries. This block replaces behavioural delay-based clock generation in testbenches and on-chip clock sources.

---
 rtl/clk_gen_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/clk_gen_ctrl.sv
// Programmable clock-generator controller.
// Produces a registered divided clock clk_out from clk. Period, high time and
// start phase are loaded through a valid/ready port; words accepted while the
// generator runs are held as pending and swapped in at the LOW->HIGH boundary
// so the output never shows a runt pulse.
module clk_gen_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_phase,
    output logic             clk_out,
    output logic             running,
    output logic             period_start,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PHASE = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

    // A word is usable only if both the high and the low part last at least one cycle.
    function automatic logic cfg_ok(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] h);
        return (p >= CNT_W'(2)) && (h >= CNT_W'(1)) && (h <= (p - CNT_W'(1)));
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   act_period_q, act_period_d;
    logic [CNT_W-1:0]   act_high_q, act_high_d;
    logic [CNT_W-1:0]   act_phase_q, act_phase_d;
    logic               cfg_loaded_q, cfg_loaded_d;
    logic               pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0]   pend_period_q, pend_period_d;
    logic [CNT_W-1:0]   pend_high_q, pend_high_d;
    logic [CNT_W-1:0]   pend_phase_q, pend_phase_d;
    logic               clk_out_q, clk_out_d;
    logic               running_q, running_d;
    logic               period_start_q, period_start_d;
    logic               cfg_err_q, cfg_err_d;
    logic               cfg_ready_q, cfg_ready_d;

    logic               accept_s;
    logic               word_ok_s;
    logic               take_idle_s;
    logic               apply_pend_s;
    logic               eff_loaded_s;
    logic [CNT_W-1:0]   eff_high_s;
    logic [CNT_W-1:0]   eff_phase_s;
    logic [CNT_W-1:0]   next_high_s;

    // Config handshake: decide where an accepted word goes and when pending becomes active.
    always_comb begin
        accept_s     = cfg_valid && cfg_ready_q;
        word_ok_s    = cfg_ok(cfg_period, cfg_high);
        // In IDLE a good word is used immediately, even on the edge that starts the FSM.
        take_idle_s  = accept_s && word_ok_s && (state_q == ST_IDLE);
        // Pending is swapped in at the end of LOW, or when PHASE aborts back to IDLE.
        apply_pend_s = pend_valid_q &&
                       (((state_q == ST_LOW) && (cnt_q == CNT_W'(0))) ||
                        ((state_q == ST_PHASE) && !enable));

        eff_loaded_s = cfg_loaded_q || take_idle_s;
        eff_high_s   = take_idle_s ? cfg_high  : act_high_q;
        eff_phase_s  = take_idle_s ? cfg_phase : act_phase_q;
        next_high_s  = apply_pend_s ? pend_high_q : act_high_q;

        act_period_d = act_period_q;
        act_high_d   = act_high_q;
        act_phase_d  = act_phase_q;
        cfg_loaded_d = cfg_loaded_q;
        if (take_idle_s) begin
            act_period_d = cfg_period;
            act_high_d   = cfg_high;
            act_phase_d  = cfg_phase;
            cfg_loaded_d = 1'b1;
        end else if (apply_pend_s) begin
            act_period_d = pend_period_q;
            act_high_d   = pend_high_q;
            act_phase_d  = pend_phase_q;
            cfg_loaded_d = 1'b1;
        end else begin
            cfg_loaded_d = cfg_loaded_q;
        end

        pend_valid_d  = pend_valid_q;
        pend_period_d = pend_period_q;
        pend_high_d   = pend_high_q;
        pend_phase_d  = pend_phase_q;
        if (accept_s && word_ok_s && (state_q != ST_IDLE)) begin
            pend_valid_d  = 1'b1;
            pend_period_d = cfg_period;
            pend_high_d   = cfg_high;
            pend_phase_d  = cfg_phase;
        end else if (apply_pend_s) begin
            pend_valid_d = 1'b0;
        end else begin
            pend_valid_d = pend_valid_q;
        end

        cfg_err_d   = accept_s && !word_ok_s;
        cfg_ready_d = !pend_valid_d;
    end

    // Sequencer: each state loads count-1 on entry and leaves when the count hits zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && eff_loaded_s) begin
                    if (eff_phase_s != CNT_W'(0)) begin
                        state_d = ST_PHASE;
                        cnt_d   = eff_phase_s - CNT_W'(1);
                    end else begin
                        state_d = ST_HIGH;
                        cnt_d   = eff_high_s - CNT_W'(1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PHASE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_W'(0);
                end else if (cnt_q == CNT_W'(0)) begin
                    state_d = ST_HIGH;
                    cnt_d   = act_high_q - CNT_W'(1);
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (cnt_q == CNT_W'(0)) begin
                    state_d = ST_LOW;
                    cnt_d   = act_period_q - act_high_q - CNT_W'(1);
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            ST_LOW: begin
                if (cnt_q == CNT_W'(0)) begin
                    if (enable) begin
                        state_d = ST_HIGH;
                        cnt_d   = next_high_s - CNT_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = CNT_W'(0);
                    end
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_W'(0);
            end
        endcase

        clk_out_d      = (state_d == ST_HIGH);
        period_start_d = (state_d == ST_HIGH) && (state_q != ST_HIGH);
        running_d      = (state_d != ST_IDLE);
    end

    // State, configuration and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= CNT_W'(0);
            act_period_q   <= CNT_W'(0);
            act_high_q     <= CNT_W'(0);
            act_phase_q    <= CNT_W'(0);
            cfg_loaded_q   <= 1'b0;
            pend_valid_q   <= 1'b0;
            pend_period_q  <= CNT_W'(0);
            pend_high_q    <= CNT_W'(0);
            pend_phase_q   <= CNT_W'(0);
            clk_out_q      <= 1'b0;
            running_q      <= 1'b0;
            period_start_q <= 1'b0;
            cfg_err_q      <= 1'b0;
            cfg_ready_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            act_period_q   <= act_period_d;
            act_high_q     <= act_high_d;
            act_phase_q    <= act_phase_d;
            cfg_loaded_q   <= cfg_loaded_d;
            pend_valid_q   <= pend_valid_d;
            pend_period_q  <= pend_period_d;
            pend_high_q    <= pend_high_d;
            pend_phase_q   <= pend_phase_d;
            clk_out_q      <= clk_out_d;
            running_q      <= running_d;
            period_start_q <= period_start_d;
            cfg_err_q      <= cfg_err_d;
            cfg_ready_q    <= cfg_ready_d;
        end
    end

    assign clk_out      = clk_out_q;
    assign running      = running_q;
    assign period_start = period_start_q;
    assign cfg_err      = cfg_err_q;
    assign cfg_ready    = cfg_ready_q;

endmodule
